// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: owner codes, arbiter states
// and the request-slot selector.
package mem_port_arbiter_pkg;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_SNES = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [1:0] OWN_MCU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNES,
    ST_ACC,
    ST_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    SEL_DMA,
    SEL_MCUW,
    SEL_MCUR
  } slot_sel_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// External SRAM/ROM pin bundle; master drives the memory, slave is the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] ram_din;
  logic              ram_oe;
  logic              ram_we;

  modport master (output ram_addr, output ram_dout, output ram_oe, output ram_we,
                  input  ram_din);
  modport slave  (input  ram_addr, input  ram_dout, input  ram_oe, input  ram_we,
                  output ram_din);
endinterface

// File: rtl/mem_req_slot.sv
// One requester slot: pending flag, latched address/data, sticky overflow.
module mem_req_slot #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic              pending,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data,
  output logic              ovf
);

  // A request landing on the clearing edge is accepted and keeps the slot busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      slot_addr <= '0;
      slot_data <= '0;
      ovf       <= 1'b0;
    end else if (req && (!pending || clr)) begin
      pending   <= 1'b1;
      slot_addr <= addr;
      slot_data <= wdata;
    end else begin
      if (req) ovf     <= 1'b1;
      if (clr) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises SNES, SD DMA and MCU accesses onto the single external memory port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 8,
  parameter int ACC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snes_req,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic              snes_we,
  input  logic [DATA_W-1:0] snes_wdata,
  output logic [DATA_W-1:0] snes_rdata,
  input  logic              mcu_rrq,
  input  logic              mcu_wrq,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [DATA_W-1:0] mcu_wdata,
  output logic [DATA_W-1:0] mcu_rdata,
  output logic              mcu_rq_rdy,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  mem_port_arbiter_if.master ram,
  output logic [1:0]        owner,
  output logic              req_ovf
);

  arb_state_t  state;
  slot_sel_t   sel;
  logic [3:0]  cnt;
  logic        acc_last;

  logic              dma_pend, mw_pend, mr_pend;
  logic [ADDR_W-1:0] dma_sa, mw_sa, mr_sa;
  logic [DATA_W-1:0] dma_sd, mw_sd, mr_sd;
  logic              dma_ovf, mw_ovf, mr_ovf;
  logic              dma_clr, mw_clr, mr_clr;

  logic              gnt_valid;
  slot_sel_t         gnt_sel;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_write;

  assign acc_last = (state == ST_ACC) && (cnt == 4'(ACC_CYCLES - 1));
  assign dma_clr  = acc_last && (sel == SEL_DMA);
  assign mw_clr   = acc_last && (sel == SEL_MCUW);
  assign mr_clr   = acc_last && (sel == SEL_MCUR);
  assign req_ovf  = dma_ovf | mw_ovf | mr_ovf;

  mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_dma (
    .clk(clk), .rst_n(rst_n), .req(dma_we), .addr(dma_addr), .wdata(dma_wdata),
    .clr(dma_clr), .pending(dma_pend), .slot_addr(dma_sa), .slot_data(dma_sd), .ovf(dma_ovf)
  );

  mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_mcuw (
    .clk(clk), .rst_n(rst_n), .req(mcu_wrq), .addr(mcu_addr), .wdata(mcu_wdata),
    .clr(mw_clr), .pending(mw_pend), .slot_addr(mw_sa), .slot_data(mw_sd), .ovf(mw_ovf)
  );

  mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_mcur (
    .clk(clk), .rst_n(rst_n), .req(mcu_rrq), .addr(mcu_addr), .wdata(mcu_wdata),
    .clr(mr_clr), .pending(mr_pend), .slot_addr(mr_sa), .slot_data(mr_sd), .ovf(mr_ovf)
  );

  always_comb begin
    gnt_valid = 1'b1;
    gnt_sel   = SEL_DMA;
    gnt_addr  = dma_sa;
    gnt_data  = dma_sd;
    gnt_write = 1'b1;
    if (dma_pend) begin
      gnt_sel = SEL_DMA;
    end else if (mw_pend) begin
      gnt_sel  = SEL_MCUW;
      gnt_addr = mw_sa;
      gnt_data = mw_sd;
    end else if (mr_pend) begin
      gnt_sel   = SEL_MCUR;
      gnt_addr  = mr_sa;
      gnt_data  = mr_sd;
      gnt_write = 1'b0;
    end else begin
      gnt_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sel          <= SEL_DMA;
      cnt          <= '0;
      ram.ram_addr <= '0;
      ram.ram_dout <= '0;
      ram.ram_oe   <= 1'b0;
      ram.ram_we   <= 1'b0;
      snes_rdata   <= '0;
      mcu_rdata    <= '0;
      mcu_rq_rdy   <= 1'b0;
      owner        <= OWN_NONE;
    end else begin
      mcu_rq_rdy <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (snes_req) begin
            state        <= ST_SNES;
            owner        <= OWN_SNES;
            ram.ram_addr <= snes_addr;
            ram.ram_dout <= snes_wdata;
            ram.ram_we   <= snes_we;
            ram.ram_oe   <= ~snes_we;
          end else if (gnt_valid) begin
            state        <= ST_ACC;
            sel          <= gnt_sel;
            cnt          <= '0;
            ram.ram_addr <= gnt_addr;
            owner        <= (gnt_sel == SEL_DMA) ? OWN_DMA : OWN_MCU;
            if (gnt_write) begin
              ram.ram_dout <= gnt_data;
              ram.ram_we   <= 1'b1;
            end else begin
              ram.ram_oe   <= 1'b1;
            end
          end
        end
        ST_SNES: begin
          if (ram.ram_oe) snes_rdata <= ram.ram_din;
          if (snes_req) begin
            ram.ram_addr <= snes_addr;
            ram.ram_dout <= snes_wdata;
            ram.ram_we   <= snes_we;
            ram.ram_oe   <= ~snes_we;
          end else begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            ram.ram_we <= 1'b0;
            ram.ram_oe <= 1'b0;
          end
        end
        ST_ACC: begin
          if (acc_last) begin
            if (sel == SEL_MCUR) mcu_rdata <= ram.ram_din;
            state      <= ST_DONE;
            owner      <= OWN_NONE;
            ram.ram_we <= 1'b0;
            ram.ram_oe <= 1'b0;
            mcu_rq_rdy <= (sel != SEL_DMA);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
